// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light sequencer timed by a synchronised 1 Hz tick, with pedestrian
// green truncation and a manual hold; all outputs registered.
module traffic_light_ctrl #(
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int PED_MIN  = 5
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       ped_req,
  input  logic       hold,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [7:0] remaining,
  output logic       sec_pulse,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } state_t;

  localparam logic [7:0] G_T   = 8'(GREEN_T);
  localparam logic [7:0] Y_T   = 8'(YELLOW_T);
  localparam logic [7:0] A_T   = 8'(ALLRED_T);
  localparam logic [7:0] PED_T = 8'(PED_MIN);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  logic       sync1, sync2, edge_q;
  state_t     state, state_nxt, succ;
  logic [7:0] rem_nxt;
  logic [2:0] ns_nxt, ew_nxt;
  logic       ped_pending, ped_nxt;
  logic       legal, is_green;

  function automatic logic [7:0] dur_of(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   dur_of = G_T;
      NS_YELLOW, EW_YELLOW: dur_of = Y_T;
      default:              dur_of = A_T;
    endcase
  endfunction

  // tick_in is asynchronous: two-flop synchroniser, then rising-edge detect
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      edge_q    <= 1'b0;
      sec_pulse <= 1'b0;
    end else begin
      sync1     <= tick_in;
      sync2     <= sync1;
      edge_q    <= sync2;
      sec_pulse <= sync2 & ~edge_q;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= NS_GREEN;
      remaining   <= G_T;
      ns_light    <= LAMP_GREEN;
      ew_light    <= LAMP_RED;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      remaining   <= rem_nxt;
      ns_light    <= ns_nxt;
      ew_light    <= ew_nxt;
      ped_pending <= ped_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    ped_nxt   = ped_pending | ped_req;
    succ      = NS_GREEN;
    legal     = 1'b1;
    is_green  = (state == NS_GREEN) || (state == EW_GREEN);
    ns_nxt    = LAMP_GREEN;
    ew_nxt    = LAMP_RED;

    case (state)
      NS_GREEN:  succ = NS_YELLOW;
      NS_YELLOW: succ = ALLRED_A;
      ALLRED_A:  succ = EW_GREEN;
      EW_GREEN:  succ = EW_YELLOW;
      EW_YELLOW: succ = ALLRED_B;
      ALLRED_B:  succ = NS_GREEN;
      default:   legal = 1'b0;
    endcase

    if (!legal) begin
      state_nxt = NS_GREEN;
      rem_nxt   = G_T;
    end else if (!hold) begin
      // Truncation takes priority and swallows a coincident tick
      if (is_green && ped_pending && (remaining > PED_T)) begin
        rem_nxt = PED_T;
      end else if (sec_pulse) begin
        if (remaining == 8'd1) begin
          state_nxt = succ;
          rem_nxt   = dur_of(succ);
          if ((succ == NS_YELLOW) || (succ == EW_YELLOW))
            ped_nxt = ped_req;
        end else begin
          rem_nxt = remaining - 8'd1;
        end
      end
    end

    case (state_nxt)
      NS_YELLOW: begin ns_nxt = LAMP_YELLOW; ew_nxt = LAMP_RED;    end
      ALLRED_A:  begin ns_nxt = LAMP_RED;    ew_nxt = LAMP_RED;    end
      EW_GREEN:  begin ns_nxt = LAMP_RED;    ew_nxt = LAMP_GREEN;  end
      EW_YELLOW: begin ns_nxt = LAMP_RED;    ew_nxt = LAMP_YELLOW; end
      ALLRED_B:  begin ns_nxt = LAMP_RED;    ew_nxt = LAMP_RED;    end
      default:   begin ns_nxt = LAMP_GREEN;  ew_nxt = LAMP_RED;    end
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: table vectors, hand-written corner sequences and a
// randomised run against a per-second model of the intersection.
module tb_traffic_light_ctrl;
  localparam int GT = 5;
  localparam int YT = 2;
  localparam int AT = 1;
  localparam int PM = 2;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0;
  logic       ped_req = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic [7:0] remaining;
  logic       sec_pulse;

  traffic_light_ctrl #(.GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT), .PED_MIN(PM)) dut (
    .clk_in(clk_in), .reset(reset), .tick_in(tick_in), .ped_req(ped_req), .hold(hold),
    .ns_light(ns_light), .ew_light(ew_light), .remaining(remaining),
    .sec_pulse(sec_pulse), .phase(phase)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Model: phase index into the cyclic order, seconds left, pending request, hold level
  int dur[6] = '{GT, YT, AT, GT, YT, AT};
  int m_idx, m_rem;
  bit m_pend, m_hold;

  typedef struct {
    bit p;
    bit h;
    int ph;
    int rem;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int ns_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  function automatic int ew_of(input int i);
    return (i == 3) ? 1 : (i == 4) ? 2 : 4;
  endfunction

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic m_settle();
    if ((m_idx == 0 || m_idx == 3) && m_pend && !m_hold && m_rem > PM) m_rem = PM;
  endtask

  task automatic m_tick();
    if (!m_hold) begin
      if (m_rem == 1) begin
        m_idx = (m_idx + 1) % 6;
        m_rem = dur[m_idx];
        if (m_idx == 1 || m_idx == 4) m_pend = 0;
      end else begin
        m_rem = m_rem - 1;
      end
    end
    m_settle();
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b1; tick_in = 1'b0; ped_req = 1'b0; hold = 1'b0;
    m_idx = 0; m_rem = GT; m_pend = 0; m_hold = 0;
    clk_n(2);
    reset = 1'b0;
    clk_n(1);
  endtask

  // One second: optional hold level, optional ped pulse, then one full tick_in period
  task automatic do_second(input bit p, input bit h);
    hold = h; m_hold = h; m_settle();
    clk_n(2);
    if (p) begin
      ped_req = 1'b1; m_pend = 1; m_settle();
      clk_n(1);
      ped_req = 1'b0;
    end
    clk_n(1);
    tick_in = 1'b1; m_tick();
    clk_n(10);
    tick_in = 1'b0;
    clk_n(8);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".phase"}, phase, m_idx);
    chk({tag, ".rem"}, remaining, m_rem);
    chk({tag, ".ns"}, ns_light, ns_of(m_idx));
    chk({tag, ".ew"}, ew_light, ew_of(m_idx));
    chk({tag, ".pend"}, dut.ped_pending, m_pend);
    chk({tag, ".onered"}, ns_light[2] | ew_light[2], 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    tbl[0]  = '{0, 0, 0, 4};  tbl[1]  = '{1, 0, 0, 1};
    tbl[2]  = '{1, 0, 1, 2};  tbl[3]  = '{1, 0, 1, 1};
    tbl[4]  = '{0, 0, 2, 1};  tbl[5]  = '{0, 0, 3, 2};
    tbl[6]  = '{0, 1, 3, 2};  tbl[7]  = '{0, 0, 3, 1};
    tbl[8]  = '{0, 0, 4, 2};  tbl[9]  = '{0, 0, 4, 1};
    tbl[10] = '{0, 0, 5, 1};  tbl[11] = '{0, 0, 0, 5};
    tbl[12] = '{0, 0, 0, 4};  tbl[13] = '{1, 1, 0, 4};
    tbl[14] = '{0, 0, 0, 1};  tbl[15] = '{0, 0, 1, 2};

    // Reset values and first tick latency
    do_reset();
    chk("rst.ns", ns_light, 3'b001);
    chk("rst.ew", ew_light, 3'b100);
    chk("rst.rem", remaining, GT);
    chk("rst.phase", phase, 0);
    chk("rst.sp", sec_pulse, 0);
    tick_in = 1'b1; m_tick();
    clk_n(2);
    chk("tick.sp_edge2", sec_pulse, 0);
    clk_n(1);
    chk("tick.sp_edge3", sec_pulse, 1);
    clk_n(1);
    chk("tick.sp_edge4", sec_pulse, 0);
    chk("tick.rem", remaining, 4);
    clk_n(6);
    tick_in = 1'b0;
    clk_n(10);

    // Pedestrian pulse at remaining=4, then a redundant request at remaining=2
    ped_req = 1'b1; m_pend = 1; m_settle();
    clk_n(1);
    ped_req = 1'b0;
    clk_n(1);
    chk("ped.rem", remaining, 2);
    chk("ped.pend", dut.ped_pending, 1);
    ped_req = 1'b1;
    clk_n(1);
    ped_req = 1'b0;
    clk_n(2);
    chk("ped.repeat_rem", remaining, 2);
    do_second(0, 0);
    do_second(0, 0);
    chk("ped.phase", phase, 1);
    chk("ped.pend_clr", dut.ped_pending, 0);

    // Request during NS_YELLOW carries to the EW_GREEN entry
    do_second(1, 0);
    chk("pedy.rem", remaining, 1);
    chk("pedy.pend", dut.ped_pending, 1);
    do_second(0, 0);
    chk("pedy.allred", phase, 2);
    tick_in = 1'b1; m_tick();
    clk_n(4);
    chk("pedy.entry_phase", phase, 3);
    chk("pedy.entry_rem", remaining, GT);
    clk_n(1);
    chk("pedy.trunc_rem", remaining, PM);
    clk_n(5);
    tick_in = 1'b0;
    clk_n(10);
    chk_model("pedy");

    // Hold across three ticks in EW_GREEN at remaining=3
    do_reset();
    repeat (10) do_second(0, 0);
    chk("hold.pre_phase", phase, 3);
    chk("hold.pre_rem", remaining, 3);
    hold = 1'b1; m_hold = 1;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick_in = 1'b1; m_tick();
      repeat (10) begin clk_n(1); pulses += int'(sec_pulse); end
      tick_in = 1'b0;
      repeat (10) begin clk_n(1); pulses += int'(sec_pulse); end
    end
    chk("hold.pulses", pulses, 3);
    chk("hold.rem", remaining, 3);
    chk("hold.phase", phase, 3);
    do_second(0, 0);
    chk("hold.release_rem", remaining, 2);

    // Asynchronous reset in the middle of EW_YELLOW
    do_reset();
    repeat (13) do_second(0, 0);
    chk("mid.phase", phase, 4);
    @(negedge clk_in);
    #2 reset = 1'b1;
    #1;
    chk("mid.ns", ns_light, 3'b001);
    chk("mid.ew", ew_light, 3'b100);
    chk("mid.rem", remaining, GT);
    chk("mid.phase0", phase, 0);
    clk_n(2);
    reset = 1'b0;
    m_idx = 0; m_rem = GT; m_pend = 0; m_hold = 0;
    clk_n(2);

    // tick_in held high for 100 cycles yields one pulse
    pulses = 0;
    tick_in = 1'b1; m_tick();
    repeat (100) begin clk_n(1); pulses += int'(sec_pulse); end
    tick_in = 1'b0;
    repeat (20) begin clk_n(1); pulses += int'(sec_pulse); end
    chk("long.pulses", pulses, 1);
    chk_model("long");

    // Table vectors from reset
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_second(tbl[i].p, tbl[i].h);
      chk($sformatf("tbl%0d.phase", i), phase, tbl[i].ph);
      chk($sformatf("tbl%0d.rem", i), remaining, tbl[i].rem);
      chk($sformatf("tbl%0d.ns", i), ns_light, ns_of(tbl[i].ph));
      chk($sformatf("tbl%0d.ew", i), ew_light, ew_of(tbl[i].ph));
    end

    // Randomised seconds against the model
    do_reset();
    for (int i = 0; i < 60; i++) begin
      do_second(($urandom % 4) == 0, ($urandom % 5) == 0);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Consumes the slow divided clock that the frequency divider produces for the traffic light (`tick_in`, one rising edge per second) and runs the two-road intersection sequence in the `clk_in` domain.
- Synchronises `tick_in` and extracts one-cycle second pulses from its rising edges.
- A six-state FSM counts those pulses to time each phase.
- Drives north-south and east-west lamp outputs plus a countdown for the display; a pedestrian request shortens the current green.

Parameters:
- GREEN_T, 20, green phase length in seconds (1..255)
- YELLOW_T, 3, yellow phase length in seconds (1..255)
- ALLRED_T, 1, all-red clearance length in seconds (1..255)
- PED_MIN, 5, green time remaining after a pedestrian truncation (1..255, PED_MIN < GREEN_T)

Ports:
- clk_in  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- tick_in  input  1  divided slow clock, ~50% duty, one rising edge per second; treated as asynchronous
- ped_req  input  1  pedestrian button, level or pulse, sampled every clk_in
- hold  input  1  high = freeze countdown and state (manual override)
- ns_light  output  3  {red,yellow,green} for north-south, exactly one bit set
- ew_light  output  3  {red,yellow,green} for east-west, exactly one bit set
- remaining  output  8  seconds left in current phase, including the current second
- sec_pulse  output  1  one-cycle pulse per detected tick_in rising edge
- phase  output  3  FSM state encoding, for debug

Behaviour:
- Reset: clocking is `clk_in`; reset is asynchronous, active-high.
  - Reset values of registers and outputs:
    - sync flops and edge flop 0, `sec_pulse` 0, `ped_pending` 0
    - state NS_GREEN (`phase` 0), `remaining` = GREEN_T
    - `ns_light` 3'b001, `ew_light` 3'b100
  - All registers are async-cleared/preset; no combinational outputs.
- Tick detection:
  - 2-flop synchroniser on `tick_in`, then edge flop.
  - `sec_pulse` is registered (sync2 & ~edge_q).
  - `sec_pulse` is high for exactly one `clk_in` cycle, asserted at the 3rd `clk_in` rising edge after `tick_in` rises, provided `tick_in` meets setup at the 1st edge.
  - A `tick_in` high for many cycles yields one pulse; falling edges yield none.
- States and encodings: NS_GREEN(0), NS_YELLOW(1), ALLRED_A(2), EW_GREEN(3), EW_YELLOW(4), ALLRED_B(5). Codes 6 and 7 are illegal and recover to NS_GREEN with `remaining` = GREEN_T on the next clock.
- Lamps per state:
  - NS_GREEN: NS green, EW red.
  - NS_YELLOW: NS yellow, EW red.
  - ALLRED_A, ALLRED_B: both red.
  - EW_GREEN: NS red, EW green.
  - EW_YELLOW: NS red, EW yellow.
  - Lamps are registered and update on the same edge as the state.
- Countdown, evaluated on a `clk_in` edge where the internal tick pulse is high and `hold` = 0:
  - If `remaining` == 1: advance to the next state in the cyclic order 0→1→2→3→4→5→0 and load that state's duration (GREEN_T, YELLOW_T or ALLRED_T) into `remaining`.
  - Otherwise decrement `remaining` by 1.
  - Each phase therefore lasts exactly its parameter in ticks; a full cycle is 2·(GREEN_T+YELLOW_T+ALLRED_T) ticks.
- `hold` = 1: ticks are discarded (not queued); state, `remaining` and lamps are frozen. `sec_pulse` still pulses.
- Pedestrian request:
  - Any clock with `ped_req` = 1 sets `ped_pending`.
  - In NS_GREEN or EW_GREEN with `ped_pending` = 1 and `remaining` > PED_MIN: `remaining` <= PED_MIN on the next clock.
  - `ped_pending` clears on entry to either yellow state.
  - If `remaining` <= PED_MIN, there is no change to `remaining` and `ped_pending` stays set until the yellow.
  - A request during yellow or all-red sets `ped_pending`, which then applies to the next green.
  - Simultaneous truncation and tick: truncation wins, `remaining` = PED_MIN, and the tick is consumed.
  - `hold` = 1 blocks truncation; `ped_pending` is still latched.
- Reset mid-phase: immediate return to reset values; a tick edge in flight through the synchroniser is lost.
- Widths: `remaining` is 8-bit unsigned. No underflow is possible, since the reload happens at 1, never at 0.

Test Plan (GREEN_T=5, YELLOW_T=2, ALLRED_T=1, PED_MIN=2; bench drives `tick_in` 50% duty, period 20 `clk_in`):
- Reset then 1 tick:
  - After reset, `ns_light`=001, `ew_light`=100, `remaining`=5, `phase`=0.
  - `sec_pulse` high for exactly 1 cycle, 3 edges after `tick_in` rises; `remaining`=4.
- 16 ticks from reset: `phase` sequence 0,1,2,3,4,5,0, with dwell of 5,2,1,5,2,1 ticks; `remaining` reads 5 after wrap. At all times at least one lamp group is red, and NS and EW are never both non-red.
- `ped_req` pulse at `remaining`=4 in NS_GREEN:
  - Next clock `remaining`=2; 2 ticks later `phase`=1 and `ped_pending`=0.
  - A repeat `ped_req` at `remaining`=2 changes nothing.
- `ped_req` during NS_YELLOW: no effect until EW_GREEN entry, then `remaining` goes 5→2 on the following clock.
- `hold`=1 across 3 ticks in EW_GREEN at `remaining`=3: `sec_pulse` pulses 3 times, `remaining` stays 3. After release, the next tick gives 2.
- Assert reset mid EW_YELLOW, and separately hold `tick_in` high for 100 cycles:
  - The reset returns outputs immediately to reset values.
  - Holding `tick_in` high yields a single `sec_pulse`.
